mult_ctrl_seq: RTL and testbench
================================

Name: mult_ctrl_seq

Overview:
- Parametrised control sequencer for the multiplier datapath.
- Debounces the start and scroll buttons, runs the load/multiply handshake, and adds a watchdog timeout with an error state.
- Owns the display scroll-window position, with wrap or saturate behaviour.
- Sits between the board buttons and the load/multiply/display blocks; successor to the fixed-function control unit.

Parameters:
- DEBOUNCE_CYCLES, 4, cycles a synchronised button level must stay stable before it is accepted (>=1).
- SCROLL_POSITIONS, 4, number of display window positions (>=2).
- POS_W, 2, width of scroll_pos; must satisfy 2^POS_W >= SCROLL_POSITIONS.
- SCROLL_WRAP, 0, 1 = wrap at the ends, 0 = saturate at the ends.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed in LOAD or MULT; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear of the FSM and scroll position only
- btn_start  in  1  raw start button (asynchronous)
- btn_left  in  1  raw scroll-left button (asynchronous)
- btn_right  in  1  raw scroll-right button (asynchronous)
- loading_done  in  1  operand load complete, level, sampled in LOAD
- mult_done  in  1  multiplier complete, level, sampled in MULT
- load_data  out  1  high while in LOAD
- mult_start  out  1  one-cycle pulse on the first cycle of MULT
- mult_active  out  1  high while in MULT
- result_valid  out  1  high while in DONE
- timeout_err  out  1  high while in ERR
- scroll_pos  out  POS_W  current display window index, 0..SCROLL_POSITIONS-1

Behaviour:
- Reset (rst):
  - All registered state cleared at the next clk edge: FSM=IDLE, scroll_pos=0, timeout counter=0, debouncer sync/stable/counters=0.
  - All outputs are 0 after reset.
- Clear (clr): same as rst except the debouncers are left untouched. rst has priority over clr.
- Debouncer, one per button:
  - 2-FF synchroniser feeds a counter that runs while the synced level differs from the stable level and resets when they match.
  - When the count reaches DEBOUNCE_CYCLES the stable level updates; a press pulse fires for exactly 1 cycle on a stable 0->1 transition.
  - Latency: the pulse is high in cycle DEBOUNCE_CYCLES+2 after the first edge sampling the button high.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse. Release produces no pulse.
- FSM states: IDLE, LOAD, MULT, DONE, ERR.
  - IDLE: start pulse -> LOAD.
  - LOAD: loading_done=1 -> MULT. Watchdog expiry -> ERR. If both happen in the same cycle, loading_done wins. mult_done is ignored here.
  - MULT: mult_done=1 -> DONE. Watchdog expiry -> ERR. If both happen in the same cycle, mult_done wins.
  - DONE: start pulse -> LOAD (rerun). Otherwise hold.
  - ERR: start pulse -> LOAD (retry). clr -> IDLE.
  - Start pulses in LOAD or MULT are ignored.
  - Unused encodings -> IDLE.
- Watchdog:
  - Counter is cleared on every state change and counts each cycle spent in LOAD or MULT.
  - When the counter equals TIMEOUT_CYCLES-1 and the exit condition is absent, the next state is ERR, so at most TIMEOUT_CYCLES cycles are spent in the state.
  - TIMEOUT_CYCLES=0: never expires.
- mult_start: registered, high exactly one cycle, coincident with the first mult_active cycle.
- Scroll:
  - scroll_pos is set to 0 on entry to DONE. Scroll pulses act only while in DONE; otherwise they are ignored.
  - Left pulse: scroll_pos+1. Right pulse: scroll_pos-1.
  - At SCROLL_POSITIONS-1 going left: wrap to 0 if SCROLL_WRAP=1, else hold.
  - At 0 going right: wrap to SCROLL_POSITIONS-1 if SCROLL_WRAP=1, else hold.
  - Left and right pulses in the same cycle: no change.
  - scroll_pos holds its value in every state other than DONE; it changes only via reset, clr, DONE entry or DONE scroll.

Test Plan:
- Reset mid-MULT: rst for 1 cycle -> next cycle all outputs 0, state IDLE, scroll_pos=0.
- Debounce (DEBOUNCE_CYCLES=4):
  - btn_start high for 3 cycles -> no LOAD entry.
  - btn_start held for 10 cycles -> exactly one start pulse at cycle 6, and load_data rises the next cycle.
- Full handshake:
  - loading_done after 5 LOAD cycles -> mult_start pulse of 1 cycle with mult_active rising.
  - mult_done after 16 cycles -> result_valid=1, scroll_pos=0.
- Timeout (TIMEOUT_CYCLES=8):
  - No loading_done -> load_data high exactly 8 cycles, then timeout_err=1.
  - Start pulse -> LOAD again.
  - Separately, mult_done on the expiry cycle -> DONE, not ERR.
- Scroll saturate (SCROLL_WRAP=0, SCROLL_POSITIONS=4) in DONE:
  - 5 left presses -> scroll_pos 1,2,3,3,3.
  - 5 right presses -> 2,1,0,0,0.
  - Left and right in the same cycle -> unchanged.
- Scroll wrap (SCROLL_WRAP=1):
  - Right press at 0 -> 3. Left press at 3 -> 0.
  - Scroll presses in IDLE or MULT -> scroll_pos unchanged.
  - clr in DONE -> IDLE, scroll_pos=0.

Source files
------------

// File: rtl/mult_ctrl_seq.sv
// Control sequencer for the multiplier datapath: button debouncing, load/multiply
// handshake with a watchdog, and the display scroll-window position.
module mult_ctrl_seq #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int SCROLL_POSITIONS = 4,
  parameter int POS_W            = 2,
  parameter int SCROLL_WRAP      = 0,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             btn_start,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             loading_done,
  input  logic             mult_done,
  output logic             load_data,
  output logic             mult_start,
  output logic             mult_active,
  output logic             result_valid,
  output logic             timeout_err,
  output logic [POS_W-1:0] scroll_pos
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SCROLL_POSITIONS - 1);

  logic [2:0] raw;
  logic [2:0] press;
  logic       start_p, left_p, right_p;

  assign raw     = {btn_right, btn_left, btn_start};
  assign start_p = press[0];
  assign left_p  = press[1];
  assign right_p = press[2];

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic          sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synced level disagrees with the accepted one.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
        if (cnt_q == DB_LAST) begin
          stable_d = sync2_q;
          press_d  = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= raw[g];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        press_q  <= press_d;
        cnt_q    <= cnt_d;
      end
    end

    assign press[g] = press_q;
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MULT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             mult_start_q, mult_start_d;
  logic             expire;

  assign expire = (TIMEOUT_CYCLES > 0) && (timer_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_p) state_d = S_LOAD;
      S_LOAD: begin
        if (loading_done)  state_d = S_MULT;
        else if (expire)   state_d = S_ERR;
      end
      S_MULT: begin
        if (mult_done)     state_d = S_DONE;
        else if (expire)   state_d = S_ERR;
      end
      S_DONE: if (start_p) state_d = S_LOAD;
      S_ERR:  if (start_p) state_d = S_LOAD;
      default:             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d = '0;
    if (state_d == state_q && (state_q == S_LOAD || state_q == S_MULT)) begin
      timer_d = timer_q + 1'b1;
    end
    mult_start_d = (state_d == S_MULT) && (state_q != S_MULT);
  end

  // Entering DONE takes precedence over scroll; left+right together cancel out.
  always_comb begin
    pos_d = pos_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      pos_d = '0;
    end else if (state_q == S_DONE && (left_p ^ right_p)) begin
      if (left_p) begin
        if (pos_q == POS_LAST) pos_d = (SCROLL_WRAP != 0) ? '0 : pos_q;
        else                   pos_d = pos_q + 1'b1;
      end else begin
        if (pos_q == '0)       pos_d = (SCROLL_WRAP != 0) ? POS_LAST : pos_q;
        else                   pos_d = pos_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pos_q        <= '0;
      mult_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pos_q        <= pos_d;
      mult_start_q <= mult_start_d;
    end
  end

  assign load_data    = (state_q == S_LOAD);
  assign mult_active  = (state_q == S_MULT);
  assign result_valid = (state_q == S_DONE);
  assign timeout_err  = (state_q == S_ERR);
  assign mult_start   = mult_start_q;
  assign scroll_pos   = pos_q;

endmodule

// File: tb/tb_mult_ctrl_seq.sv
// Bench for mult_ctrl_seq: two instances (saturating/long watchdog, wrapping/short
// watchdog) checked against a cycle-level behavioural model of the control rules.
module tb_mult_ctrl_seq;

  localparam int DB   = 4;
  localparam int NPOS = 4;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_MULT = 2, PH_DONE = 3, PH_ERR = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clr, bs, bl, br, ld, md;
  logic [1:0] o_load, o_ms, o_ma, o_rv, o_te;
  logic [1:0] pos0, pos1;

  int checks = 0;
  int errors = 0;

  int m_s1[2][3], m_s2[2][3], m_st[2][3], m_cnt[2][3], m_pl[2][3];
  int m_ph[2], m_tmr[2], m_pos[2], m_ms[2];

  always #5 clk = ~clk;

  mult_ctrl_seq #(
    .DEBOUNCE_CYCLES(DB), .SCROLL_POSITIONS(NPOS), .POS_W(2),
    .SCROLL_WRAP(0), .TIMEOUT_CYCLES(32)
  ) u_sat (
    .clk(clk), .rst(rst), .clr(clr[0]),
    .btn_start(bs[0]), .btn_left(bl[0]), .btn_right(br[0]),
    .loading_done(ld[0]), .mult_done(md[0]),
    .load_data(o_load[0]), .mult_start(o_ms[0]), .mult_active(o_ma[0]),
    .result_valid(o_rv[0]), .timeout_err(o_te[0]), .scroll_pos(pos0)
  );

  mult_ctrl_seq #(
    .DEBOUNCE_CYCLES(DB), .SCROLL_POSITIONS(NPOS), .POS_W(2),
    .SCROLL_WRAP(1), .TIMEOUT_CYCLES(8)
  ) u_wrap (
    .clk(clk), .rst(rst), .clr(clr[1]),
    .btn_start(bs[1]), .btn_left(bl[1]), .btn_right(br[1]),
    .loading_done(ld[1]), .mult_done(md[1]),
    .load_data(o_load[1]), .mult_start(o_ms[1]), .mult_active(o_ma[1]),
    .result_valid(o_rv[1]), .timeout_err(o_te[1]), .scroll_pos(pos1)
  );

  function automatic int wrap_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int to_of(int i);
    return (i == 1) ? 8 : 32;
  endfunction

  // One clock of the reference behaviour for instance i, using pre-edge inputs.
  task automatic model_step(int i);
    int raw[3];
    int np[3];
    int oldp, nxt, sp, lp, rp;
    raw[0] = int'(bs[i]); raw[1] = int'(bl[i]); raw[2] = int'(br[i]);
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[i][b] = 0; m_s2[i][b] = 0; m_st[i][b] = 0; m_cnt[i][b] = 0; m_pl[i][b] = 0;
      end
      m_ph[i] = PH_IDLE; m_tmr[i] = 0; m_pos[i] = 0; m_ms[i] = 0;
      return;
    end
    sp = m_pl[i][0]; lp = m_pl[i][1]; rp = m_pl[i][2];
    for (int b = 0; b < 3; b++) begin
      np[b] = 0;
      if (m_s2[i][b] != m_st[i][b]) begin
        m_cnt[i][b]++;
        if (m_cnt[i][b] == DB) begin
          m_st[i][b] = m_s2[i][b];
          m_cnt[i][b] = 0;
          np[b] = m_st[i][b];
        end
      end else begin
        m_cnt[i][b] = 0;
      end
      m_s2[i][b] = m_s1[i][b];
      m_s1[i][b] = raw[b];
    end
    if (clr[i]) begin
      m_ph[i] = PH_IDLE; m_tmr[i] = 0; m_pos[i] = 0; m_ms[i] = 0;
    end else begin
      oldp = m_ph[i];
      nxt  = oldp;
      case (oldp)
        PH_IDLE: if (sp != 0) nxt = PH_LOAD;
        PH_LOAD: if (ld[i]) nxt = PH_MULT;
                 else if (to_of(i) != 0 && m_tmr[i] + 1 >= to_of(i)) nxt = PH_ERR;
        PH_MULT: if (md[i]) nxt = PH_DONE;
                 else if (to_of(i) != 0 && m_tmr[i] + 1 >= to_of(i)) nxt = PH_ERR;
        default: if (sp != 0) nxt = PH_LOAD;
      endcase
      if (nxt != oldp || !(nxt == PH_LOAD || nxt == PH_MULT)) m_tmr[i] = 0;
      else m_tmr[i]++;
      m_ms[i] = (nxt == PH_MULT && oldp != PH_MULT) ? 1 : 0;
      if (nxt == PH_DONE && oldp != PH_DONE) begin
        m_pos[i] = 0;
      end else if (oldp == PH_DONE && lp != rp) begin
        if (lp != 0) m_pos[i] = (m_pos[i] == NPOS - 1) ? (wrap_of(i) ? 0 : m_pos[i]) : m_pos[i] + 1;
        else         m_pos[i] = (m_pos[i] == 0) ? (wrap_of(i) ? NPOS - 1 : 0) : m_pos[i] - 1;
      end
      m_ph[i] = nxt;
    end
    for (int b = 0; b < 3; b++) m_pl[i][b] = np[b];
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  function automatic logic [6:0] exp_vec(int i);
    return {m_ph[i] == PH_LOAD, m_ms[i] != 0, m_ph[i] == PH_MULT,
            m_ph[i] == PH_DONE, m_ph[i] == PH_ERR, 2'(m_pos[i])};
  endfunction

  function automatic logic [6:0] obs_vec(int i);
    if (i == 0) return {o_load[0], o_ms[0], o_ma[0], o_rv[0], o_te[0], pos0};
    return {o_load[1], o_ms[1], o_ma[1], o_rv[1], o_te[1], pos1};
  endfunction

  // Idle long enough for any earlier release to settle, then hold the buttons;
  // returns on the cycle the resulting pulse has acted on the FSM.
  task automatic press(int i, logic s, logic l, logic r);
    repeat (7) cyc();
    bs[i] = s; bl[i] = l; br[i] = r;
    repeat (7) cyc();
    bs[i] = 1'b0; bl[i] = 1'b0; br[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== 7'd0) begin
        errors++; $display("FAIL reset_outputs inst=%0d got=%b exp=%b", i, obs_vec(i), 7'd0);
      end
      checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL reset_model inst=%0d got=%b exp=%b", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_debounce();
    int glen[3];
    int seen, first;
    glen[0] = 3;
    glen[1] = int'($urandom_range(1, DB - 1));
    glen[2] = int'($urandom_range(1, DB - 1));
    for (int g = 0; g < 3; g++) begin
      bs[0] = 1'b1;
      repeat (glen[g]) cyc();
      bs[0] = 1'b0;
      seen = 0;
      repeat (10) begin
        cyc();
        if (o_load[0] !== 1'b0) seen = 1;
      end
      checks++;
      if (seen != 0) begin
        errors++; $display("FAIL glitch_no_load len=%0d got=%0d exp=0", glen[g], seen);
      end
    end
    bs[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (first == 0 && o_load[0] === 1'b1) first = k;
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL deb_track cyc=%0d got=%b exp=%b", k, obs_vec(0), exp_vec(0));
      end
    end
    bs[0] = 1'b0;
    checks++;
    if (first != 7) begin
      errors++; $display("FAIL deb_latency got=%0d exp=7", first);
    end
    repeat (12) cyc();
    checks++;
    if (obs_vec(0) !== 7'b1000000) begin
      errors++; $display("FAIL deb_release got=%b exp=%b", obs_vec(0), 7'b1000000);
    end
    clr[0] = 1'b1; cyc(); clr[0] = 1'b0;
    checks++;
    if (obs_vec(0) !== 7'd0) begin
      errors++; $display("FAIL deb_clr got=%b exp=%b", obs_vec(0), 7'd0);
    end
  endtask

  task automatic test_handshake();
    int ldd, mdd;
    for (int rep = 0; rep < 4; rep++) begin
      ldd = (rep == 0) ? 5  : int'($urandom_range(1, 12));
      mdd = (rep == 0) ? 16 : int'($urandom_range(2, 20));
      press(0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec(0) !== 7'b1000000) begin
        errors++; $display("FAIL hs_load_entry rep=%0d got=%b exp=%b", rep, obs_vec(0), 7'b1000000);
      end
      if (rep != 0) md[0] = 1'b1;
      repeat (ldd - 1) cyc();
      ld[0] = 1'b1; md[0] = 1'b0;
      cyc();
      ld[0] = 1'b0;
      checks++;
      if (obs_vec(0) !== 7'b0110000) begin
        errors++; $display("FAIL hs_mult_start rep=%0d got=%b exp=%b", rep, obs_vec(0), 7'b0110000);
      end
      cyc();
      checks++;
      if (obs_vec(0) !== 7'b0010000) begin
        errors++; $display("FAIL hs_mult_hold rep=%0d got=%b exp=%b", rep, obs_vec(0), 7'b0010000);
      end
      repeat (mdd - 2) cyc();
      md[0] = 1'b1;
      cyc();
      md[0] = 1'b0;
      checks++;
      if (obs_vec(0) !== 7'b0001000) begin
        errors++; $display("FAIL hs_done rep=%0d got=%b exp=%b", rep, obs_vec(0), 7'b0001000);
      end
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL hs_model rep=%0d got=%b exp=%b", rep, obs_vec(0), exp_vec(0));
      end
    end
    press(0, 1'b1, 1'b0, 1'b0);
    press(0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec(0) !== 7'b1000000) begin
      errors++; $display("FAIL hs_start_in_load got=%b exp=%b", obs_vec(0), 7'b1000000);
    end
    clr[0] = 1'b1; cyc(); clr[0] = 1'b0;
  endtask

  task automatic test_timeout();
    int n, k;
    clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
    press(1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (o_load[1] === 1'b1 && n < 20) begin n++; cyc(); end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL to_load_cycles got=%0d exp=8", n);
    end
    checks++;
    if (obs_vec(1) !== 7'b0000100) begin
      errors++; $display("FAIL to_err got=%b exp=%b", obs_vec(1), 7'b0000100);
    end
    repeat (3) cyc();
    checks++;
    if (obs_vec(1) !== 7'b0000100) begin
      errors++; $display("FAIL to_err_hold got=%b exp=%b", obs_vec(1), 7'b0000100);
    end
    press(1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec(1) !== 7'b1000000) begin
      errors++; $display("FAIL to_retry got=%b exp=%b", obs_vec(1), 7'b1000000);
    end
    repeat (7) cyc();
    ld[1] = 1'b1; cyc(); ld[1] = 1'b0;
    checks++;
    if (obs_vec(1) !== 7'b0110000) begin
      errors++; $display("FAIL to_ld_on_expiry got=%b exp=%b", obs_vec(1), 7'b0110000);
    end
    repeat (7) cyc();
    md[1] = 1'b1; cyc(); md[1] = 1'b0;
    checks++;
    if (obs_vec(1) !== 7'b0001000) begin
      errors++; $display("FAIL to_md_on_expiry got=%b exp=%b", obs_vec(1), 7'b0001000);
    end
    press(1, 1'b1, 1'b0, 1'b0);
    k = int'($urandom_range(1, 7));
    repeat (k - 1) cyc();
    ld[1] = 1'b1; cyc(); ld[1] = 1'b0;
    n = 0;
    while (o_ma[1] === 1'b1 && n < 20) begin n++; cyc(); end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL to_mult_cycles got=%0d exp=8", n);
    end
    checks++;
    if (obs_vec(1) !== exp_vec(1) || obs_vec(1) !== 7'b0000100) begin
      errors++; $display("FAIL to_mult_err got=%b exp=%b", obs_vec(1), exp_vec(1));
    end
    clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
    checks++;
    if (obs_vec(1) !== 7'd0) begin
      errors++; $display("FAIL to_clr_err got=%b exp=%b", obs_vec(1), 7'd0);
    end
  endtask

  task automatic test_scroll_sat();
    int exp_l[5];
    int exp_r[5];
    int d;
    exp_l = '{1, 2, 3, 3, 3};
    exp_r = '{2, 1, 0, 0, 0};
    press(0, 1'b1, 1'b0, 1'b0);
    ld[0] = 1'b1; cyc(); ld[0] = 1'b0;
    md[0] = 1'b1; cyc(); md[0] = 1'b0;
    checks++;
    if (obs_vec(0) !== 7'b0001000) begin
      errors++; $display("FAIL sat_done got=%b exp=%b", obs_vec(0), 7'b0001000);
    end
    for (int k = 0; k < 5; k++) begin
      press(0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (pos0 !== 2'(exp_l[k])) begin
        errors++; $display("FAIL sat_left k=%0d got=%0d exp=%0d", k, pos0, exp_l[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      press(0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (pos0 !== 2'(exp_r[k])) begin
        errors++; $display("FAIL sat_right k=%0d got=%0d exp=%0d", k, pos0, exp_r[k]);
      end
    end
    press(0, 1'b0, 1'b1, 1'b0);
    press(0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (pos0 !== 2'd1) begin
      errors++; $display("FAIL sat_both got=%0d exp=1", pos0);
    end
    for (int k = 0; k < 6; k++) begin
      d = int'($urandom_range(0, 2));
      press(0, 1'b0, d != 1, d != 0);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL sat_rand k=%0d got=%b exp=%b", k, obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_scroll_wrap();
    clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
    press(1, 1'b1, 1'b0, 1'b0);
    ld[1] = 1'b1; cyc(); ld[1] = 1'b0;
    md[1] = 1'b1; cyc(); md[1] = 1'b0;
    press(1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pos1 !== 2'd3) begin
      errors++; $display("FAIL wrap_right got=%0d exp=3", pos1);
    end
    press(1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pos1 !== 2'd0) begin
      errors++; $display("FAIL wrap_left got=%0d exp=0", pos1);
    end
    press(1, 1'b0, 1'b0, 1'b1);
    press(1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec(1) !== 7'b1000011) begin
      errors++; $display("FAIL wrap_hold_load got=%b exp=%b", obs_vec(1), 7'b1000011);
    end
    ld[1] = 1'b1; cyc(); ld[1] = 1'b0;
    bl[1] = 1'b1;
    repeat (7) cyc();
    checks++;
    if (obs_vec(1) !== 7'b0010011) begin
      errors++; $display("FAIL wrap_ignore_mult got=%b exp=%b", obs_vec(1), 7'b0010011);
    end
    bl[1] = 1'b0;
    md[1] = 1'b1; cyc(); md[1] = 1'b0;
    checks++;
    if (obs_vec(1) !== 7'b0001000) begin
      errors++; $display("FAIL wrap_done_entry got=%b exp=%b", obs_vec(1), 7'b0001000);
    end
    press(1, 1'b0, 1'b0, 1'b1);
    clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
    checks++;
    if (obs_vec(1) !== 7'd0) begin
      errors++; $display("FAIL wrap_clr_done got=%b exp=%b", obs_vec(1), 7'd0);
    end
    press(1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec(1) !== 7'd0 || obs_vec(1) !== exp_vec(1)) begin
      errors++; $display("FAIL wrap_ignore_idle got=%b exp=%b", obs_vec(1), 7'd0);
    end
  endtask

  task automatic test_reset_mid_mult();
    press(0, 1'b1, 1'b0, 1'b0);
    ld[0] = 1'b1; cyc(); ld[0] = 1'b0;
    repeat (3) cyc();
    checks++;
    if (o_ma[0] !== 1'b1) begin
      errors++; $display("FAIL rst_pre_mult got=%b exp=1", o_ma[0]);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== 7'd0 || obs_vec(i) !== exp_vec(i)) begin
        errors++; $display("FAIL rst_mid_mult inst=%0d got=%b exp=%b", i, obs_vec(i), 7'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = '0; bs = '0; bl = '0; br = '0; ld = '0; md = '0;
    test_reset();
    test_debounce();
    test_handshake();
    test_timeout();
    test_scroll_sat();
    test_scroll_wrap();
    test_reset_mid_mult();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
